// File: rtl/lpif_tx_stage_fifo.sv
// First-word-fall-through staging FIFO between the link layer and the LPIF PHY transmit inputs.
// Dropping linkUp flushes every buffered beat. A flush of a non-empty FIFO raises a one-cycle flush_pulse.
module lpif_tx_stage_fifo #(
    parameter int DATA_W = 512,
    parameter int BYTES  = 64,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic                CLK,
    input  logic                lpreset,
    input  logic                linkUp,
    input  logic                ll_irdy,
    output logic                ll_trdy,
    input  logic [DATA_W-1:0]   ll_data,
    input  logic [BYTES-1:0]    ll_valid,
    input  logic [BYTES-1:0]    ll_dlpstart,
    input  logic [BYTES-1:0]    ll_dlpend,
    input  logic [BYTES-1:0]    ll_tlpstart,
    input  logic [BYTES-1:0]    ll_tlpend,
    output logic                lp_irdy,
    input  logic                pl_trdy,
    output logic [DATA_W-1:0]   lp_data,
    output logic [BYTES-1:0]    lp_valid,
    output logic [BYTES-1:0]    lp_dlpstart,
    output logic [BYTES-1:0]    lp_dlpend,
    output logic [BYTES-1:0]    lp_tlpstart,
    output logic [BYTES-1:0]    lp_tlpend,
    output logic [ADDR_W:0]     fifo_count,
    output logic                flush_pulse
);

    localparam int              ENTRY_W    = DATA_W + 5 * BYTES;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               flush_pulse_q, flush_pulse_d;
    logic               wr_en, rd_en;
    logic [ENTRY_W-1:0] head;

    // The handshakes depend only on registered state, so a full FIFO never passes a beat through.
    assign ll_trdy = ~lpreset & linkUp & (count_q != FULL_COUNT);
    assign lp_irdy = ~lpreset & linkUp & (count_q != '0);
    assign wr_en   = ll_irdy & ll_trdy;
    assign rd_en   = lp_irdy & pl_trdy;

    always_comb begin
        // NOTE: every target gets a default before any branch, so no latch is inferred.
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        flush_pulse_d = 1'b0;
        if (!linkUp) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            flush_pulse_d = (count_q != '0);
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + ADDR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
                2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge lpreset) begin
        if (lpreset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            flush_pulse_q <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            flush_pulse_q <= flush_pulse_d;
        end
    end

    // NOTE: the storage array has no reset. An entry is only visible after it has been written.
    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {ll_data, ll_valid, ll_dlpstart, ll_dlpend, ll_tlpstart, ll_tlpend};
        end
    end

    assign head = lp_irdy ? mem_q[rd_ptr_q] : '0;
    assign {lp_data, lp_valid, lp_dlpstart, lp_dlpend, lp_tlpstart, lp_tlpend} = head;
    assign fifo_count  = count_q;
    assign flush_pulse = flush_pulse_q;

endmodule
